// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states
// and small elaboration helpers.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } exec_state_t;

  // Step counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int unsigned mul_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH steps
// after i_start. o_done_c flags the final step and o_product_c carries its sum.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_product_c
);

  localparam int unsigned CW = mul_cnt_width(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  // Accumulator value after the current step; the product on the last one.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  assign o_done_c    = (r_cnt == CW'(1));
  assign o_product_c = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle AND/OR/ADD/SUB, iterative MUL,
// registered result/zero/illegal held until downstream takes them.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  exec_state_t      r_state;
  exec_state_t      w_state_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_legal;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  assign w_accept    = in_valid & in_ready;
  assign w_is_mul    = (operation == OP_MUL);
  assign w_mul_start = w_accept & w_is_mul;

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_mul_start),
    .i_a        (a),
    .i_b        (b),
    .o_done_c   (w_mul_done),
    .o_product_c(w_mul_product)
  );

  // Single-cycle datapath; illegal codes yield a zero result.
  always_comb begin
    w_alu_res = '0;
    w_legal   = 1'b1;
    case (operation)
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_ADD:  w_alu_res = a + b;
      OP_SUB:  w_alu_res = a + ~b + WIDTH'(1);
      OP_MUL:  w_alu_res = '0;
      default: w_legal   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? MUL : DONE;
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            w_state_next = w_is_mul ? MUL : DONE;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    out_valid = (r_state == DONE);
    busy      = (r_state == MUL);
  end

  // Result registers only move on a new single-cycle accept or MUL completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result  <= w_alu_res;
      r_zero    <= (w_alu_res == '0);
      r_illegal <= ~w_legal;
    end else if ((r_state == MUL) && w_mul_done) begin
      r_result  <= w_mul_product;
      r_zero    <= (w_mul_product == '0);
      r_illegal <= 1'b0;
    end
  end

  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WIDTH=64): a transaction-level model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  alu_exec_unit #(.WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operation(operation),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          acyc;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    int          cyc;
    int          acyc;
  } log_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mul_cnt = 0;
  logic en = 1'b0;
  exp_t q[$];
  log_t lg[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural meaning of each operation code.
  function automatic exp_t model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    e.ill  = 1'b0;
    e.acyc = 0;
    case (o)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: e.res = x + y;
      4'b0110: e.res = x - y;
      4'b1000: e.res = x * y;
      default: begin e.res = 64'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    if (en) begin
      logic exp_ov;
      logic exp_ir;
      exp_t e;
      log_t l;
      exp_ov = (q.size() != 0) && (mul_cnt == 0);
      exp_ir = (mul_cnt == 0) && ((q.size() == 0) || out_ready);
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("busy", 64'(busy), 64'(mul_cnt != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      if (exp_ov) begin
        chk("result", result, q[0].res);
        chk("zero", 64'(zero), 64'(q[0].zero));
        chk("illegal", 64'(illegal), 64'(q[0].ill));
      end
      if (reset) begin
        q.delete();
        mul_cnt = 0;
      end else begin
        if (mul_cnt > 0) mul_cnt--;
        if (exp_ov && out_ready) begin
          e = q.pop_front();
          l.res = result; l.zero = zero; l.ill = illegal; l.cyc = cyc; l.acyc = e.acyc;
          lg.push_back(l);
        end
        if (in_valid && exp_ir) begin
          e = model(operation, a, b);
          e.acyc = cyc;
          q.push_back(e);
          if (operation == 4'b1000) mul_cnt = 64;
        end
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    int n = 0;
    in_valid = 1'b1; operation = o; a = x; b = y;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy_n);
    int n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
    end while ((out_valid || busy) && n < 300);
    if (out_valid || busy) chk("drain_timeout", 64'(out_valid | busy), 64'd0);
    @(posedge clk); #2;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [63:0] res,
                         input logic z, input logic il);
    if (idx >= lg.size()) begin
      chk({name, "_missing"}, 64'(lg.size()), 64'(idx + 1));
    end else begin
      chk({name, "_res"}, lg[idx].res, res);
      chk({name, "_zero"}, 64'(lg[idx].zero), 64'(z));
      chk({name, "_ill"}, 64'(lg[idx].ill), 64'(il));
    end
  endtask

  function automatic int lat(input int idx);
    return (idx < lg.size()) ? (lg[idx].cyc - lg[idx].acyc) : -1;
  endfunction

  function automatic int cyc_of(input int idx);
    return (idx < lg.size()) ? lg[idx].cyc : -1;
  endfunction

  initial begin
    int base;
    int bn;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operation = 4'b0000; a = 64'd0; b = 64'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0; en = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;

    // Back-to-back single-cycle ops
    out_ready = 1'b1;
    base = lg.size();
    send(4'b0010, 64'd5, 64'd7);
    send(4'b0110, 64'd3, 64'd5);
    send(4'b0110, 64'd9, 64'd9);
    send(4'b0000, 64'hF0, 64'h3C);
    send(4'b0001, 64'hF0, 64'h0F);
    wait_idle(bn);
    chk_log("add", base, 64'd12, 1'b0, 1'b0);
    chk_log("sub_neg", base + 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    chk_log("sub_zero", base + 2, 64'd0, 1'b1, 1'b0);
    chk_log("and", base + 3, 64'h30, 1'b0, 1'b0);
    chk_log("or", base + 4, 64'hFF, 1'b0, 1'b0);
    chk("single_latency", 64'(lat(base)), 64'd1);
    for (int i = 1; i < 5; i++) chk("consecutive", 64'(cyc_of(base + i) - cyc_of(base)), 64'(i));

    // MUL
    base = lg.size();
    send(4'b1000, 64'h1234, 64'h10);
    wait_idle(bn);
    chk("mul_busy_cycles", 64'(bn), 64'd64);
    chk("mul_latency", 64'(lat(base)), 64'd65);
    chk_log("mul1", base, 64'h12340, 1'b0, 1'b0);
    send(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_idle(bn);
    chk("mul2_busy_cycles", 64'(bn), 64'd64);
    chk_log("mul2", base + 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    // Backpressure with a waiting request
    base = lg.size();
    out_ready = 1'b0;
    send(4'b0010, 64'd1, 64'd1);
    in_valid = 1'b1; operation = 4'b0110; a = 64'd10; b = 64'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", result, 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_sub_result", result, 64'd6);
    wait_idle(bn);
    chk_log("bp_add", base, 64'd2, 1'b0, 1'b0);
    chk_log("bp_sub", base + 1, 64'd6, 1'b0, 1'b0);
    chk("bp_sub_next_cycle", 64'(cyc_of(base + 1) - cyc_of(base)), 64'd1);

    // Illegal code, then a legal op clears the flag
    base = lg.size();
    send(4'b0101, 64'd3, 64'd4);
    send(4'b0010, 64'd3, 64'd4);
    wait_idle(bn);
    chk_log("illegal", base, 64'd0, 1'b1, 1'b1);
    chk_log("after_illegal", base + 1, 64'd7, 1'b0, 1'b0);

    // Reset in the middle of a MUL
    base = lg.size();
    send(4'b1000, 64'd3, 64'd5);
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_result", result, 64'd0);
    chk("mrst_zero", 64'(zero), 64'd1);
    chk("mrst_illegal", 64'(illegal), 64'd0);
    @(posedge clk); #2;
    send(4'b0010, 64'd2, 64'd2);
    wait_idle(bn);
    chk("mrst_no_mul_result", 64'(lg.size()), 64'(base + 1));
    chk_log("post_rst_add", base, 64'd4, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
